// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU execution controller: state encoding and widths.
package cpu_ctrl_pkg;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    PAUSE  = 2'd0,
    STEP   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } exec_state_e;
endpackage

// File: rtl/cpu_exec_controller_if.sv
// Board-side and CPU-side signals of the execution controller.
interface cpu_exec_controller_if
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 8
);
  logic               RunSw;
  logic               StepKey;
  logic               Halt;
  logic [PC_W-1:0]    Pc;
  logic [PC_W-1:0]    BreakAddr;
  logic               BreakEn;
  logic               CpuEn;
  logic [STATE_W-1:0] State;
  logic [CNT_W-1:0]   StepCnt;

  modport slave (
    input  RunSw, StepKey, Halt, Pc, BreakAddr, BreakEn,
    output CpuEn, State, StepCnt
  );

  modport master (
    output RunSw, StepKey, Halt, Pc, BreakAddr, BreakEn,
    input  CpuEn, State, StepCnt
  );
endinterface

// File: rtl/key_debouncer.sv
// Push-button synchroniser and debouncer; emits a one-cycle pulse per accepted press.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic StepKey,
  output logic press
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s1;
  logic             key_s;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Any return of the synced key to the accepted level restarts the count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      key_s1 <= 1'b0;
      key_s  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      key_s1 <= StepKey;
      key_s  <= key_s1;
      press  <= 1'b0;
      if (key_s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= key_s;
        cnt    <= '0;
        press  <= key_s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/cpu_exec_controller.sv
// Generates the CPU execute strobe: divided free-run, debounced single-step,
// PC breakpoint and sticky halt.
module cpu_exec_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned RUN_DIV         = 4,
  parameter int unsigned PC_W            = 8
) (
  input logic Clock,
  input logic Reset,
  cpu_exec_controller_if.slave bus
);
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic             run_s1;
  logic             run_s;
  logic             press;
  exec_state_e      state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             strobe_due;
  logic             bp_hit;
  logic             cpu_en;
  logic [CNT_W-1:0] step_cnt;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .Clock   (Clock),
    .Reset   (Reset),
    .StepKey (bus.StepKey),
    .press   (press)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      run_s1 <= bus.RunSw;
      run_s  <= run_s1;
    end
  end

  // CpuEn is a flop, so the strobe is decided on the edge that moves the
  // divider onto its last count.
  always_comb begin
    div_nxt    = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    strobe_due = (div_nxt == DIV_LAST);
    bp_hit     = bus.BreakEn && (PC_W'(bus.Pc) == PC_W'(bus.BreakAddr));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= PAUSE;
      div      <= '0;
      cpu_en   <= 1'b0;
      step_cnt <= '0;
    end else begin
      cpu_en <= 1'b0;
      if (cpu_en) step_cnt <= step_cnt + CNT_W'(1);
      case (state)
        PAUSE: begin
          if (bus.Halt) begin
            state <= HALTED;
          end else if (run_s) begin
            state <= RUN;
            div   <= '0;
          end else if (press) begin
            state  <= STEP;
            cpu_en <= 1'b1;
          end
        end
        STEP:   state <= bus.Halt ? HALTED : PAUSE;
        RUN: begin
          if (bus.Halt) begin
            state <= HALTED;
          end else if (!run_s) begin
            state <= PAUSE;
          end else begin
            div <= div_nxt;
            if (strobe_due) begin
              if (bp_hit) state  <= PAUSE;
              else        cpu_en <= 1'b1;
            end
          end
        end
        HALTED:  state <= HALTED;
        default: state <= PAUSE;
      endcase
    end
  end

  assign bus.CpuEn   = cpu_en;
  assign bus.State   = state;
  assign bus.StepCnt = step_cnt;
endmodule

// File: tb/tb_cpu_exec_controller.sv
// Self-checking bench for cpu_exec_controller: vector table, directed corner cases,
// randomized run against a behavioural model, and StepCnt wrap on a RUN_DIV=1 instance.
module tb_cpu_exec_controller;
  localparam int DB = 4;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  always #5 clk = ~clk;

  cpu_exec_controller_if #(.PC_W(8)) bus ();
  cpu_exec_controller_if #(.PC_W(8)) bus_w ();

  cpu_exec_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD), .PC_W(8)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  cpu_exec_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(1), .PC_W(8)) u_wrap (
    .Clock (clk),
    .Reset (rst_w),
    .bus   (bus_w)
  );

  int n_vec = 0;
  int n_bad = 0;
  int pulses = 0;

  // Reference model state
  logic       m_r0, m_r1, m_k0, m_k1, m_stable, m_press, m_en;
  logic [1:0] m_state;
  int         m_cyc;
  logic [15:0] m_cnt;
  bit         kh[$];

  typedef struct {
    bit          run;
    bit          key;
    bit          halt;
    int          cycles;
    logic [1:0]  exp_state;
    logic [15:0] exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void model_reset();
    m_r0 = 0; m_r1 = 0; m_k0 = 0; m_k1 = 0;
    m_stable = 0; m_press = 0; m_en = 0;
    m_state = 2'd0; m_cyc = 0; m_cnt = 16'd0;
    kh.delete();
  endfunction

  // One clock edge of behaviour: inputs seen through two-stage delays, key accepted
  // after DB consecutive differing samples, run strobes every RD-th cycle in RUN.
  function automatic void model_step();
    logic run_s, key_s, prs, en;
    run_s = m_r1; key_s = m_k1; prs = m_press; en = m_en;
    m_r1 = m_r0; m_r0 = bus.RunSw;
    m_k1 = m_k0; m_k0 = bus.StepKey;
    m_press = 0;
    if (key_s == m_stable) kh.delete();
    else begin
      kh.push_back(key_s);
      if (kh.size() == DB) begin
        m_stable = key_s;
        m_press  = key_s;
        kh.delete();
      end
    end
    if (en) m_cnt = m_cnt + 16'd1;
    m_en = 0;
    case (m_state)
      2'd0: begin
        if (bus.Halt) m_state = 2'd3;
        else if (run_s) begin m_state = 2'd2; m_cyc = 1; end
        else if (prs) begin m_state = 2'd1; m_en = 1; end
      end
      2'd1: m_state = bus.Halt ? 2'd3 : 2'd0;
      2'd2: begin
        if (bus.Halt) m_state = 2'd3;
        else if (!run_s) m_state = 2'd0;
        else begin
          m_cyc++;
          if (m_cyc % RD == 0) begin
            if (bus.BreakEn && bus.Pc == bus.BreakAddr) m_state = 2'd0;
            else m_en = 1;
          end
        end
      end
      default: m_state = 2'd3;
    endcase
  endfunction

  task automatic tick();
    logic en_prev;
    en_prev = m_en;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    if (!rst && en_prev) bus.Pc = bus.Pc + 8'd1;
    if (bus.CpuEn === 1'b1) pulses++;
    check("cycle", {13'd0, bus.State, bus.CpuEn, bus.StepCnt}, {13'd0, m_state, m_en, m_cnt});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    ticks(2);
    rst = 1'b0;
  endtask

  vec_t tbl[6];
  int halted_cycles;

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    bus.RunSw = 0; bus.StepKey = 0; bus.Halt = 0; bus.Pc = 8'd0; bus.BreakAddr = 8'd0; bus.BreakEn = 0;
    bus_w.RunSw = 0; bus_w.StepKey = 0; bus_w.Halt = 0; bus_w.Pc = 8'd0; bus_w.BreakAddr = 8'd0; bus_w.BreakEn = 0;
    model_reset();
    @(negedge clk);
    ticks(3);
    check("reset_outputs", {13'd0, bus.State, bus.CpuEn, bus.StepCnt}, 32'd0);
    rst = 1'b0;

    tbl[0] = '{run:0, key:1, halt:0, cycles:10, exp_state:2'd0, exp_cnt:16'd1};
    tbl[1] = '{run:0, key:0, halt:0, cycles:10, exp_state:2'd0, exp_cnt:16'd1};
    tbl[2] = '{run:1, key:0, halt:0, cycles:10, exp_state:2'd2, exp_cnt:16'd2};
    tbl[3] = '{run:0, key:0, halt:0, cycles:6,  exp_state:2'd0, exp_cnt:16'd3};
    tbl[4] = '{run:0, key:1, halt:1, cycles:2,  exp_state:2'd3, exp_cnt:16'd3};
    tbl[5] = '{run:1, key:1, halt:0, cycles:20, exp_state:2'd3, exp_cnt:16'd3};
    foreach (tbl[i]) begin
      bus.RunSw = tbl[i].run; bus.StepKey = tbl[i].key; bus.Halt = tbl[i].halt;
      ticks(tbl[i].cycles);
      check($sformatf("table_state_%0d", i), {30'd0, bus.State}, {30'd0, tbl[i].exp_state});
      check($sformatf("table_cnt_%0d", i), {16'd0, bus.StepCnt}, {16'd0, tbl[i].exp_cnt});
    end
    bus.RunSw = 0; bus.StepKey = 0; bus.Halt = 0;
    do_reset();

    // Reset asserted while a run strobe is high
    bus.RunSw = 1;
    ticks(10);
    check("pre_reset_pulse", {15'd0, bus.CpuEn, bus.StepCnt}, {15'd0, 1'b1, 16'd1});
    #1 rst = 1'b1;
    model_reset();
    #1 check("async_reset", {13'd0, bus.State, bus.CpuEn, bus.StepCnt}, 32'd0);
    @(negedge clk);
    ticks(3);
    bus.RunSw = 0;
    rst = 1'b0;
    ticks(10);
    check("stay_pause", {30'd0, bus.State}, 32'd0);

    // Bounced press yields exactly one step
    pulses = 0;
    bus.StepKey = 1; tick();
    bus.StepKey = 0; tick();
    bus.StepKey = 1; ticks(10);
    bus.StepKey = 0; ticks(12);
    check("bounce_pulses", pulses, 1);
    check("bounce_cnt", {16'd0, bus.StepCnt}, 32'd1);
    check("bounce_state", {30'd0, bus.State}, 32'd0);

    // Free run and stop
    pulses = 0;
    bus.RunSw = 1; ticks(40);
    check_range("run_pulses", pulses, 9, 11);
    bus.RunSw = 0; ticks(2);
    pulses = 0; ticks(20);
    check("no_pulse_after_stop", pulses, 0);

    // Breakpoint, step past, rerun
    do_reset();
    bus.Pc = 8'h03; bus.BreakAddr = 8'h05; bus.BreakEn = 1;
    pulses = 0;
    bus.RunSw = 1; ticks(20);
    bus.RunSw = 0; ticks(10);
    check("bp_pulses", pulses, 2);
    check("bp_pc", {24'd0, bus.Pc}, 32'h05);
    check("bp_state", {30'd0, bus.State}, 32'd0);
    pulses = 0;
    bus.StepKey = 1; ticks(10);
    bus.StepKey = 0; ticks(10);
    check("bp_step_pulse", pulses, 1);
    check("bp_step_pc", {24'd0, bus.Pc}, 32'h06);
    pulses = 0;
    bus.RunSw = 1; ticks(20);
    check("bp_rerun_pulses", pulses, 4);
    bus.RunSw = 0; bus.BreakEn = 0;

    // Halt coinciding with a press event
    do_reset();
    bus.StepKey = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_press) break;
    end
    bus.Halt = 1; pulses = 0;
    tick();
    bus.Halt = 0;
    check("halt_state", {30'd0, bus.State}, 32'd3);
    for (int i = 0; i < 30; i++) begin
      bus.RunSw = 1;
      bus.StepKey = (i / 6) % 2;
      tick();
    end
    check("halt_sticky_pulses", pulses, 0);
    check("halt_sticky_state", {30'd0, bus.State}, 32'd3);
    bus.RunSw = 0; bus.StepKey = 0;

    // Randomized stimulus against the model
    do_reset();
    halted_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) bus.RunSw = ~bus.RunSw;
      if ($urandom_range(0, 5) == 0) bus.StepKey = ~bus.StepKey;
      bus.Halt = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 49) == 0) begin
        bus.BreakEn = 1'($urandom_range(0, 1));
        bus.BreakAddr = bus.Pc + 8'($urandom_range(1, 3));
      end
      if (m_state == 2'd3) halted_cycles++;
      if (halted_cycles > 15 || $urandom_range(0, 699) == 0) begin
        halted_cycles = 0;
        bus.Halt = 0;
        do_reset();
      end
      tick();
    end

    // StepCnt wrap on the RUN_DIV=1 instance
    rst = 1'b1;
    rst_w = 1'b0;
    bus_w.RunSw = 1;
    for (int n = 1; n <= 65540; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 100) check("wrap_cnt_100", {16'd0, bus_w.StepCnt}, 32'd96);
      if (n == 65539) check("wrap_cnt_ffff", {16'd0, bus_w.StepCnt}, 32'h0000FFFF);
      if (n == 65540) begin
        check("wrap_cnt_zero", {16'd0, bus_w.StepCnt}, 32'd0);
        check("wrap_cpuen", {31'd0, bus_w.CpuEn}, 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
